// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD display scanner: segment patterns (active-high gfedcba)
// and the digit-slot state encoding.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_4digit_display_scan_if.sv
// Result-in / display-out bundle of the BCD display scanner.
// master: adder side plus display consumer; slave: the scanner itself.
interface bcd_4digit_display_scan_if;
  logic        load;
  logic [15:0] bcd_in;
  logic        carry_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        ovf_led;
  logic        frame_done;

  modport master (
    output load, bcd_in, carry_in,
    input  seg, dp, an, ovf_led, frame_done
  );

  modport slave (
    input  load, bcd_in, carry_in,
    output seg, dp, an, ovf_led, frame_done
  );
endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high {g,f,e,d,c,b,a} pattern.
// Nibbles 10..15 are not BCD and show 'E'.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_4digit_display_scan.sv
// Time-multiplexed 4-digit 7-segment driver for a packed-BCD sum with frame-synchronous commit.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_4digit_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  bcd_4digit_display_scan_if.slave bus
);

  localparam int              CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [3:0]      AN_OFF  = AN_ACTIVE_LOW ? 4'hF : 4'h0;
  localparam logic [6:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DP_OFF  = SEG_ACTIVE_LOW;

  logic [CNT_W-1:0] scan_cnt;
  digit_t           digit;
  logic [15:0]      shadow_bcd;
  logic             shadow_carry;
  logic [15:0]      committed_bcd;
  logic             committed_carry;
  logic             pending;

  logic             tick;
  logic             boundary;
  logic [3:0]       nibble;
  logic [6:0]       pattern;
  logic [6:0]       shown;
  logic             blank;
  logic [3:0]       slot_an;
  logic             dp_lit;

  logic [6:0]       seg_q;
  logic             dp_q;
  logic [3:0]       an_q;
  logic             ovf_q;
  logic             frame_done_q;

  assign tick     = (scan_cnt == CNT_MAX);
  assign boundary = tick && (digit == DIG3);

  always_comb begin
    nibble  = committed_bcd[3:0];
    slot_an = 4'b0001;
    case (digit)
      DIG0: begin nibble = committed_bcd[3:0];   slot_an = 4'b0001; end
      DIG1: begin nibble = committed_bcd[7:4];   slot_an = 4'b0010; end
      DIG2: begin nibble = committed_bcd[11:8];  slot_an = 4'b0100; end
      DIG3: begin nibble = committed_bcd[15:12]; slot_an = 4'b1000; end
      default: begin nibble = committed_bcd[3:0]; slot_an = 4'b0001; end
    endcase
  end

  bcd_to_7seg u_dec (
    .nibble (nibble),
    .seg    (pattern)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is leading only if it and everything above it is zero; an invalid nibble is never zero.
  always_comb begin
    blank = 1'b0;
    case (digit)
      DIG1:    blank = (committed_bcd[15:4]  == 12'd0);
      DIG2:    blank = (committed_bcd[15:8]  == 8'd0);
      DIG3:    blank = (committed_bcd[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  assign shown  = blank ? SEG_BLANK : pattern;
  assign dp_lit = (digit == DIG3) && committed_carry;

  // Prescaler, digit FSM and the registered display outputs (one cycle behind the slot state).
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt     <= '0;
      digit        <= DIG0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      an_q         <= AN_OFF;
      ovf_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + CNT_W'(1);
      if (tick) begin
        case (digit)
          DIG0:    digit <= DIG1;
          DIG1:    digit <= DIG2;
          DIG2:    digit <= DIG3;
          DIG3:    digit <= DIG0;
          default: digit <= DIG0;
        endcase
      end
      seg_q        <= SEG_ACTIVE_LOW ? ~shown : shown;
      dp_q         <= SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
      an_q         <= AN_ACTIVE_LOW ? ~slot_an : slot_an;
      ovf_q        <= committed_carry;
      frame_done_q <= boundary;
    end
  end

  // New results wait in the shadow until a frame boundary so no frame mixes old and new digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_bcd      <= '0;
      shadow_carry    <= 1'b0;
      committed_bcd   <= '0;
      committed_carry <= 1'b0;
      pending         <= 1'b0;
    end else if (bus.load && boundary) begin
      committed_bcd   <= bus.bcd_in;
      committed_carry <= bus.carry_in;
      pending         <= 1'b0;
    end else begin
      if (boundary && pending) begin
        committed_bcd   <= shadow_bcd;
        committed_carry <= shadow_carry;
        pending         <= 1'b0;
      end
      if (bus.load) begin
        shadow_bcd   <= bus.bcd_in;
        shadow_carry <= bus.carry_in;
        pending      <= 1'b1;
      end
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.ovf_led    = ovf_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_4digit_display_scan.sv
// Directed self-checking bench for bcd_4digit_display_scan (SCAN_DIV=4, active-low seg/an).
// Expectations follow LEADING_ZERO_BLANK_EN when the bench is built with it defined.
module tb_bcd_4digit_display_scan;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  bcd_4digit_display_scan_if bus_if ();

  bcd_4digit_display_scan #(
    .SCAN_DIV       (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packed frame {d3,d2,d1,d0} of a committed 0000 as seen on the active-low segments.
  function automatic logic [27:0] zero_frame();
`ifdef LEADING_ZERO_BLANK_EN
    return {7'h7F, 7'h7F, 7'h7F, 7'h40};
`else
    return {7'h40, 7'h40, 7'h40, 7'h40};
`endif
  endfunction

  // Starting at a frame_done sample, records the next 16 samples (one full frame).
  task automatic read_frame(output logic [27:0] segs, output logic [3:0] dps,
                            output bit an_bad, output bit fd_bad, output bit slot_bad);
    logic [3:0] exp_an;
    int d;
    segs = '0; dps = '0; an_bad = 1'b0; fd_bad = 1'b0; slot_bad = 1'b0;
    for (int s = 0; s < 16; s++) begin
      step();
      d = s / 4;
      exp_an = ~(4'b0001 << d);
      if (bus_if.an !== exp_an) an_bad = 1'b1;
      if (bus_if.frame_done !== (s == 15)) fd_bad = 1'b1;
      if (s % 4 == 0) begin
        segs[7*d +: 7] = bus_if.seg;
        dps[d] = bus_if.dp;
      end else if (bus_if.seg !== segs[7*d +: 7] || bus_if.dp !== dps[d]) begin
        slot_bad = 1'b1;
      end
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      if (bus_if.frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic do_load(input logic [15:0] value, input logic carry);
    bus_if.load = 1'b1;
    bus_if.bcd_in = value;
    bus_if.carry_in = carry;
    step();
    bus_if.load = 1'b0;
  endtask

  task automatic test_reset();
    logic [27:0] segs; logic [3:0] dps; bit an_bad, fd_bad, slot_bad;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus_if.an !== 4'hF) begin fails++; $display("[TB] FAIL reset_an: got %b expected 1111", bus_if.an); end
    checks++; if (bus_if.seg !== 7'h7F) begin fails++; $display("[TB] FAIL reset_seg: got %h expected 7f", bus_if.seg); end
    checks++; if (bus_if.dp !== 1'b1) begin fails++; $display("[TB] FAIL reset_dp: got %b expected 1", bus_if.dp); end
    checks++; if (bus_if.ovf_led !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus_if.ovf_led); end
    checks++; if (bus_if.frame_done !== 1'b0) begin fails++; $display("[TB] FAIL reset_fd: got %b expected 0", bus_if.frame_done); end
    rst = 1'b0;
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (an_bad !== 1'b0) begin fails++; $display("[TB] FAIL reset_an_walk: got bad=%b expected 0", an_bad); end
    checks++; if (fd_bad !== 1'b0) begin fails++; $display("[TB] FAIL reset_fd_period: got bad=%b expected 0", fd_bad); end
    checks++; if (segs !== zero_frame() || slot_bad !== 1'b0) begin fails++; $display("[TB] FAIL reset_digits: got %h expected %h", segs, zero_frame()); end
    checks++; if (dps !== 4'hF) begin fails++; $display("[TB] FAIL reset_dps: got %b expected 1111", dps); end
  endtask

  task automatic test_commit_mid_frame();
    logic [27:0] segs; logic [3:0] dps; bit an_bad, fd_bad, slot_bad, ok, stale_bad;
    logic [27:0] zf;
    int d;
    zf = zero_frame();
    repeat (5) step();
    do_load(16'h1234, 1'b0);
    stale_bad = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      step();
      d = 0;
      for (int k = 0; k < 4; k++) if (bus_if.an === ~(4'b0001 << k)) d = k;
      if (bus_if.seg !== zf[7*d +: 7]) stale_bad = 1'b1;
      if (bus_if.frame_done === 1'b1) ok = 1'b1;
    end
    checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL load_boundary_timeout: got %b expected 1", ok); end
    checks++; if (stale_bad !== 1'b0) begin fails++; $display("[TB] FAIL load_early_update: got bad=%b expected 0", stale_bad); end
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (segs !== {7'h79, 7'h24, 7'h30, 7'h19} || slot_bad !== 1'b0) begin fails++; $display("[TB] FAIL load_1234: got %h expected %h", segs, {7'h79, 7'h24, 7'h30, 7'h19}); end
    checks++; if (dps !== 4'hF) begin fails++; $display("[TB] FAIL load_1234_dp: got %b expected 1111", dps); end
    checks++; if (an_bad !== 1'b0 || fd_bad !== 1'b0) begin fails++; $display("[TB] FAIL load_1234_scan: got an_bad=%b fd_bad=%b expected 0 0", an_bad, fd_bad); end
  endtask

  task automatic test_carry();
    logic [27:0] segs; logic [3:0] dps; bit an_bad, fd_bad, slot_bad, ok;
    do_load(16'h0000, 1'b1);
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL carry_boundary_timeout: got %b expected 1", ok); end
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (segs !== zero_frame() || slot_bad !== 1'b0) begin fails++; $display("[TB] FAIL carry_digits: got %h expected %h", segs, zero_frame()); end
    checks++; if (dps !== 4'b0111) begin fails++; $display("[TB] FAIL carry_dp: got %b expected 0111", dps); end
    checks++; if (bus_if.ovf_led !== 1'b1) begin fails++; $display("[TB] FAIL carry_ovf: got %b expected 1", bus_if.ovf_led); end
    checks++; if (an_bad !== 1'b0 || fd_bad !== 1'b0) begin fails++; $display("[TB] FAIL carry_scan: got an_bad=%b fd_bad=%b expected 0 0", an_bad, fd_bad); end
  endtask

  task automatic test_back_to_back();
    logic [27:0] segs; logic [3:0] dps; bit an_bad, fd_bad, slot_bad, ok;
    do_load(16'h1111, 1'b0);
    repeat (3) step();
    do_load(16'h9999, 1'b0);
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL b2b_boundary_timeout: got %b expected 1", ok); end
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (segs !== {4{7'h10}} || slot_bad !== 1'b0) begin fails++; $display("[TB] FAIL b2b_last_wins: got %h expected %h", segs, {4{7'h10}}); end
    checks++; if (bus_if.ovf_led !== 1'b0 || dps !== 4'hF) begin fails++; $display("[TB] FAIL b2b_ovf_clear: got ovf=%b dp=%b expected 0 1111", bus_if.ovf_led, dps); end
    // Now sitting on a frame_done sample; 15 more edges reach the cycle of the next boundary tick.
    repeat (15) step();
    do_load(16'h5555, 1'b0);
    checks++; if (bus_if.frame_done !== 1'b1) begin fails++; $display("[TB] FAIL tick_align: got %b expected 1", bus_if.frame_done); end
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (segs !== {4{7'h12}} || slot_bad !== 1'b0) begin fails++; $display("[TB] FAIL load_on_tick: got %h expected %h", segs, {4{7'h12}}); end
    checks++; if (an_bad !== 1'b0 || fd_bad !== 1'b0) begin fails++; $display("[TB] FAIL tick_scan: got an_bad=%b fd_bad=%b expected 0 0", an_bad, fd_bad); end
  endtask

  task automatic test_invalid_nibble();
    logic [27:0] segs; logic [3:0] dps; bit an_bad, fd_bad, slot_bad, ok;
    logic [27:0] exp_segs;
`ifdef LEADING_ZERO_BLANK_EN
    exp_segs = {7'h7F, 7'h7F, 7'h06, 7'h78};
`else
    exp_segs = {7'h40, 7'h40, 7'h06, 7'h78};
`endif
    do_load(16'h00A7, 1'b0);
    wait_frame(ok);
    checks++; if (ok !== 1'b1) begin fails++; $display("[TB] FAIL invalid_boundary_timeout: got %b expected 1", ok); end
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (segs !== exp_segs || slot_bad !== 1'b0) begin fails++; $display("[TB] FAIL invalid_00A7: got %h expected %h", segs, exp_segs); end
    checks++; if (dps !== 4'hF) begin fails++; $display("[TB] FAIL invalid_dp: got %b expected 1111", dps); end
  endtask

  task automatic test_reset_mid_frame();
    logic [27:0] segs; logic [3:0] dps; bit an_bad, fd_bad, slot_bad;
    do_load(16'h8888, 1'b1);
    repeat (8) step();
    rst = 1'b1;
    step();
    checks++; if (bus_if.an !== 4'hF || bus_if.seg !== 7'h7F || bus_if.dp !== 1'b1) begin fails++; $display("[TB] FAIL midrst_outputs: got an=%b seg=%h dp=%b expected 1111 7f 1", bus_if.an, bus_if.seg, bus_if.dp); end
    checks++; if (bus_if.ovf_led !== 1'b0 || bus_if.frame_done !== 1'b0) begin fails++; $display("[TB] FAIL midrst_flags: got ovf=%b fd=%b expected 0 0", bus_if.ovf_led, bus_if.frame_done); end
    rst = 1'b0;
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (an_bad !== 1'b0 || fd_bad !== 1'b0) begin fails++; $display("[TB] FAIL midrst_restart: got an_bad=%b fd_bad=%b expected 0 0", an_bad, fd_bad); end
    checks++; if (segs !== zero_frame() || slot_bad !== 1'b0) begin fails++; $display("[TB] FAIL midrst_digits: got %h expected %h", segs, zero_frame()); end
    read_frame(segs, dps, an_bad, fd_bad, slot_bad);
    checks++; if (segs !== zero_frame() || dps !== 4'hF || bus_if.ovf_led !== 1'b0) begin fails++; $display("[TB] FAIL midrst_pending_dropped: got %h dp=%b ovf=%b expected %h 1111 0", segs, dps, bus_if.ovf_led, zero_frame()); end
  endtask

  initial begin
    checks = 0;
    fails = 0;
    rst = 1'b1;
    bus_if.load = 1'b0;
    bus_if.bcd_in = 16'h0000;
    bus_if.carry_in = 1'b0;
    test_reset();
    test_commit_mid_frame();
    test_carry();
    test_back_to_back();
    test_invalid_nibble();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
